// File: rtl/ma_mem_access_if.sv
// Data-bus interface between the memory-access stage and the data memory / peripherals.
// The master drives request, strobes and write data; the slave answers with ack and read data.
interface ma_mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_byteen,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_byteen,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/ma_mem_access.sv
// Memory-access stage engine: turns the MA-slot load/store into a req/ack bus transaction,
// stalls the pipeline while it is outstanding, checks address faults (AdEL/AdES) and
// extends load data. Optional bus timeout (DBE) is enabled by defining MA_TIMEOUT_EN.
module ma_mem_access #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] DM_TOP  = 32'h0000_2FFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_i,
    input  logic                    valid_in_i,
    input  logic [3:0]              mem_op_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    ma_mem_access_if.master         dbus,
    output logic                    stall_o,
    output logic                    done_o,
    output logic [31:0]             dm_data_o,
    output logic                    exc_valid_o,
    output logic [4:0]              exc_code_o
);

    localparam logic [3:0] OpLw  = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLb  = 4'd4;
    localparam logic [3:0] OpLbu = 4'd5;
    localparam logic [3:0] OpSw  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSb  = 4'd8;

    localparam logic [4:0] ExcAdel = 5'd4;
    localparam logic [4:0] ExcAdes = 5'd5;
    localparam logic [4:0] ExcDbe  = 5'd7;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_byteen_q, bus_byteen_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] dm_data_q, dm_data_d;
    logic        done_q, done_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        is_load, is_store, misalign, in_dm, in_tmr, fault;
    logic        capture, ack_take, timeout_hit, timeout_take, op_q_load;
    logic [3:0]  byteen_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode the incoming op and classify address faults.
    always_comb begin
        is_load  = (mem_op_i >= OpLw) && (mem_op_i <= OpLbu);
        is_store = (mem_op_i >= OpSw) && (mem_op_i <= OpSb);
        misalign = (((mem_op_i == OpLw) || (mem_op_i == OpSw)) && (addr_i[1:0] != 2'b00)) ||
                   (((mem_op_i == OpLh) || (mem_op_i == OpLhu) || (mem_op_i == OpSh)) &&
                    addr_i[0]);
        in_dm    = addr_i <= DM_TOP;
        in_tmr   = ((addr_i >= 32'h7F00) && (addr_i <= 32'h7F0B)) ||
                   ((addr_i >= 32'h7F10) && (addr_i <= 32'h7F1B));
        // Timer registers only accept full-word stores.
        fault    = valid_in_i && (is_load || is_store) &&
                   (misalign || !(in_dm || in_tmr) ||
                    (((mem_op_i == OpSh) || (mem_op_i == OpSb)) && in_tmr));
    end

    // Byte enables and write-lane replication for the access being captured.
    always_comb begin
        byteen_c = 4'b1111;
        wdata_c  = wdata_i;
        if (mem_op_i == OpSh) begin
            byteen_c = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c  = {2{wdata_i[15:0]}};
        end else if (mem_op_i == OpSb) begin
            byteen_c = 4'b0001 << addr_i[1:0];
            wdata_c  = {4{wdata_i[7:0]}};
        end
    end

    // Select and extend the loaded byte/half from the bus read data.
    always_comb begin
        op_q_load = (op_q >= OpLw) && (op_q <= OpLbu);
        unique case (off_q)
            2'd0:    ld_byte = dbus.bus_rdata[7:0];
            2'd1:    ld_byte = dbus.bus_rdata[15:8];
            2'd2:    ld_byte = dbus.bus_rdata[23:16];
            default: ld_byte = dbus.bus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dbus.bus_rdata[31:16] : dbus.bus_rdata[15:0];
        case (op_q)
            OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_ext = {24'd0, ld_byte};
            OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_ext = {16'd0, ld_half};
            default: ld_ext = dbus.bus_rdata;
        endcase
    end

`ifdef MA_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // Count REQ cycles; restart whenever the FSM is not waiting on the bus.
    always_comb begin
        timeout_hit = (tmo_cnt_q == TIMEOUT - 1);
        tmo_cnt_d   = (state_q == StReq && state_d == StReq) ? tmo_cnt_q + 32'd1 : 32'd0;
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) tmo_cnt_q <= 32'd0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM next state and stall; a flush always wins over ack or timeout.
    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        capture      = 1'b0;
        ack_take     = 1'b0;
        timeout_take = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fault && valid_in_i && (is_load || is_store) && !req_i) begin
                    stall_o = 1'b1;
                    capture = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (req_i) begin
                    state_d = StIdle;
                end else if (dbus.bus_ack) begin
                    ack_take = 1'b1;
                    state_d  = StDone;
                end else if (timeout_hit) begin
                    timeout_take = 1'b1;
                    state_d      = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next-state for the bus, result and exception registers.
    always_comb begin
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_byteen_d = bus_byteen_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        dm_data_d    = dm_data_q;
        op_d         = op_q;
        off_d        = off_q;
        done_d       = (state_q == StReq) && (state_d == StDone);
        exc_valid_d  = timeout_take;
        exc_code_d   = timeout_take ? ExcDbe : 5'd0;
        if (capture) begin
            bus_req_d    = 1'b1;
            bus_we_d     = is_store;
            bus_byteen_d = byteen_c;
            bus_addr_d   = {addr_i[31:2], 2'b00};
            bus_wdata_d  = wdata_c;
            op_d         = mem_op_i;
            off_d        = addr_i[1:0];
            dm_data_d    = 32'd0;
        end
        if (state_q == StReq && state_d != StReq) begin
            bus_req_d    = 1'b0;
            bus_we_d     = 1'b0;
            bus_byteen_d = 4'd0;
            bus_addr_d   = 32'd0;
            bus_wdata_d  = 32'd0;
        end
        if (ack_take && op_q_load) dm_data_d = ld_ext;
        if (state_q == StDone && req_i) dm_data_d = 32'd0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_byteen_q <= 4'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            dm_data_q    <= 32'd0;
            done_q       <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= 5'd0;
            op_q         <= 4'd0;
            off_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_byteen_q <= bus_byteen_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            dm_data_q    <= dm_data_d;
            done_q       <= done_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            op_q         <= op_d;
            off_q        <= off_d;
        end
    end

    // Outputs: address faults are reported combinationally, bus errors from registers.
    always_comb begin
        dbus.bus_req    = bus_req_q;
        dbus.bus_we     = bus_we_q;
        dbus.bus_byteen = bus_byteen_q;
        dbus.bus_addr   = bus_addr_q;
        dbus.bus_wdata  = bus_wdata_q;
        done_o          = done_q;
        dm_data_o       = dm_data_q;
        exc_valid_o     = exc_valid_q || ((state_q == StIdle) && fault);
        if (exc_valid_q)  exc_code_o = exc_code_q;
        else if (is_load) exc_code_o = ExcAdel;
        else              exc_code_o = ExcAdes;
    end

endmodule

// File: tb/tb_ma_mem_access.sv
// Directed bench for ma_mem_access: load results are queued as they are issued and
// compared when the DUT reports done.
module tb_ma_mem_access;
    logic        clk = 1'b0;
    logic        reset, req, valid_in;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        stall, done, exc_valid;
    logic [31:0] dm_data;
    logic [4:0]  exc_code;

    int passed = 0;
    int total  = 0;
    logic [31:0] sb_q[$];

    ma_mem_access_if dbus();

    ma_mem_access #(.TIMEOUT(16), .DM_TOP(32'h0000_2FFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .valid_in_i (valid_in),
        .mem_op_i   (mem_op),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .dbus       (dbus),
        .stall_o    (stall),
        .done_o     (done),
        .dm_data_o  (dm_data),
        .exc_valid_o(exc_valid),
        .exc_code_o (exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Full access: one IDLE cycle, nreq REQ cycles with ack on the last, then DONE.
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int nreq,
                             input logic we, input logic [3:0] be, input logic [31:0] bwd,
                             input logic [31:0] dm);
        valid_in = 1'b1;
        mem_op   = op;
        addr     = a;
        wdata    = wd;
        sb_q.push_back(dm);
        sample();
        chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_idle_req"}, {31'd0, dbus.bus_req}, 32'd0);
        for (int i = 0; i < nreq; i++) begin
            step();
            dbus.bus_ack   = (i == nreq - 1);
            dbus.bus_rdata = (i == nreq - 1) ? rd : 32'h5A5A_5A5A;
            sample();
            chk({tag, "_req_stall"}, {31'd0, stall}, 32'd1);
            chk({tag, "_bus_req"}, {31'd0, dbus.bus_req}, 32'd1);
            if (i == 0) begin
                chk({tag, "_we"}, {31'd0, dbus.bus_we}, {31'd0, we});
                chk({tag, "_byteen"}, {28'd0, dbus.bus_byteen}, {28'd0, be});
                chk({tag, "_addr"}, dbus.bus_addr, {a[31:2], 2'b00});
                if (we) chk({tag, "_wdata"}, dbus.bus_wdata, bwd);
            end
        end
        step();
        dbus.bus_ack = 1'b0;
        valid_in     = 1'b0;
        mem_op       = 4'd0;
        sample();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done_req"}, {31'd0, dbus.bus_req}, 32'd0);
        if (sb_q.size() == 0) begin
            total++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            chk({tag, "_dm_data"}, dm_data, sb_q.pop_front());
        end
        step();
        sample();
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        step();
    endtask

    // Address fault: same-cycle exception, no stall, no bus activity.
    task automatic do_fault(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [4:0] code);
        valid_in = 1'b1;
        mem_op   = op;
        addr     = a;
        sample();
        chk({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd1);
        chk({tag, "_exc_code"}, {27'd0, exc_code}, {27'd0, code});
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        step();
        valid_in = 1'b0;
        mem_op   = 4'd0;
        sample();
        chk({tag, "_no_bus"}, {31'd0, dbus.bus_req}, 32'd0);
        chk({tag, "_exc_clr"}, {31'd0, exc_valid}, 32'd0);
        step();
    endtask

    initial begin
        reset          = 1'b1;
        req            = 1'b0;
        valid_in       = 1'b0;
        mem_op         = 4'd0;
        addr           = 32'd0;
        wdata          = 32'd0;
        dbus.bus_ack   = 1'b0;
        dbus.bus_rdata = 32'd0;
        step();
        step();
        sample();
        chk("rst_bus_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("rst_byteen", {28'd0, dbus.bus_byteen}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dm_data", dm_data, 32'd0);
        chk("rst_exc", {31'd0, exc_valid}, 32'd0);
        step();
        reset = 1'b0;

        do_access("lb",  4'd4, 32'h3,   32'h0, 32'h80FF_1234, 1, 1'b0, 4'b1111, 32'h0,
                  32'hFFFF_FF80);
        do_access("lbu", 4'd5, 32'h3,   32'h0, 32'h80FF_1234, 1, 1'b0, 4'b1111, 32'h0,
                  32'h0000_0080);
        do_access("sh",  4'd7, 32'h102, 32'h1234_ABCD, 32'h0, 3, 1'b1, 4'b1100,
                  32'hABCD_ABCD, 32'h0);
        do_access("lh",  4'd2, 32'h2,   32'h0, 32'h8001_7FFF, 2, 1'b0, 4'b1111, 32'h0,
                  32'hFFFF_8001);
        do_access("lhu", 4'd3, 32'h0,   32'h0, 32'h8001_9FFF, 1, 1'b0, 4'b1111, 32'h0,
                  32'h0000_9FFF);
        do_access("sb",  4'd8, 32'h5,   32'h0000_00AB, 32'h0, 1, 1'b1, 4'b0010,
                  32'hABAB_ABAB, 32'h0);
        do_access("sw_tmr", 4'd6, 32'h7F08, 32'hDEAD_0001, 32'h0, 1, 1'b1, 4'b1111,
                  32'hDEAD_0001, 32'h0);

        do_fault("lw_mis", 4'd1, 32'h6,    5'd4);
        do_fault("sb_tmr", 4'd8, 32'h7F04, 5'd5);
        do_fault("sw_oor", 4'd6, 32'h3000, 5'd5);
        do_fault("lh_gap", 4'd2, 32'h7F0C, 5'd4);

        // Flush arriving together with ack discards the read.
        valid_in = 1'b1;
        mem_op   = 4'd1;
        addr     = 32'h20;
        sample();
        step();
        dbus.bus_ack   = 1'b1;
        dbus.bus_rdata = 32'hCAFE_F00D;
        req            = 1'b1;
        sample();
        chk("flush_in_req", {31'd0, dbus.bus_req}, 32'd1);
        step();
        dbus.bus_ack = 1'b0;
        req          = 1'b0;
        valid_in     = 1'b0;
        mem_op       = 4'd0;
        sample();
        chk("flush_bus_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_dm_data", dm_data, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_exc", {31'd0, exc_valid}, 32'd0);
        step();
        do_access("lw_after", 4'd1, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0,
                  32'hDEAD_BEEF);

        // Reset while a transaction is outstanding.
        valid_in = 1'b1;
        mem_op   = 4'd1;
        addr     = 32'h44;
        sample();
        step();
        reset = 1'b1;
        sample();
        chk("mid_rst_req", {31'd0, dbus.bus_req}, 32'd1);
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        mem_op   = 4'd0;
        sample();
        chk("mid_rst_bus_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("mid_rst_byteen", {28'd0, dbus.bus_byteen}, 32'd0);
        chk("mid_rst_addr", dbus.bus_addr, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_exc", {31'd0, exc_valid}, 32'd0);
        dbus.bus_ack = 1'b1;
        step();
        dbus.bus_ack = 1'b0;
        sample();
        chk("stray_ack_done", {31'd0, done}, 32'd0);
        chk("stray_ack_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("stray_ack_dm", dm_data, 32'd0);
        step();

        // Bus never acknowledges.
        valid_in = 1'b1;
        mem_op   = 4'd1;
        addr     = 32'h40;
        sample();
`ifdef MA_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            step();
            sample();
            if (i == 15) begin
                chk("tmo_last_req", {31'd0, dbus.bus_req}, 32'd1);
                chk("tmo_last_stall", {31'd0, stall}, 32'd1);
            end
        end
        step();
        valid_in = 1'b0;
        mem_op   = 4'd0;
        sample();
        chk("tmo_exc_valid", {31'd0, exc_valid}, 32'd1);
        chk("tmo_exc_code", {27'd0, exc_code}, 32'd7);
        chk("tmo_bus_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        chk("tmo_dm_data", dm_data, 32'd0);
        step();
`else
        for (int i = 0; i < 100; i++) begin
            step();
            sample();
        end
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_bus_req", {31'd0, dbus.bus_req}, 32'd1);
        chk("wait_no_exc", {31'd0, exc_valid}, 32'd0);
        step();
        dbus.bus_ack   = 1'b1;
        dbus.bus_rdata = 32'h1122_3344;
        sample();
        step();
        dbus.bus_ack = 1'b0;
        valid_in     = 1'b0;
        mem_op       = 4'd0;
        sample();
        chk("wait_done", {31'd0, done}, 32'd1);
        chk("wait_dm_data", dm_data, 32'h1122_3344);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
